// File: rtl/game_frame_sequencer.sv
// rtl/game_frame_sequencer.sv - per-frame object update sequencer and game state machine
//
// Purpose: runs the game state machine (IDLE, INIT, RUN, OVER) and, once per
// frame at the rising edge of v_sync, grants one update slot to each object
// client in index order using a one-hot req / single-cycle ack handshake.
//
// Optional feature macro: GAME_FRAME_SEQ_AUTO_RESTART_EN
//   defined   : OVER returns to INIT on the v_sync edge that completes the hold
//   undefined : OVER returns to INIT on a start_btn edge after the hold
//
// Ports:
//   clock        system/pixel clock
//   reset        asynchronous active-low reset
//   v_sync       vertical sync, active-high, synchronous to clock
//   start_btn    start/restart button, debounced, active-high
//   collision    game-over level from collision logic
//   upd_req      one-hot update request to object i
//   upd_ack      single-cycle acknowledge from object i
//   obj_init     one-cycle pulse: objects load start positions
//   game_state   0=IDLE 1=INIT 2=RUN 3=OVER
//   frame_count  frames sequenced since last INIT (wraps)
//   overrun      sticky: v_sync edge arrived mid-sequence
//   ack_timeout  sticky: a request expired without ack
module game_frame_sequencer #(
  parameter int NUM_OBJ          = 4,
  parameter int ACK_TIMEOUT      = 255,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               v_sync,
  input  logic               start_btn,
  input  logic               collision,
  output logic [NUM_OBJ-1:0] upd_req,
  input  logic [NUM_OBJ-1:0] upd_ack,
  output logic               obj_init,
  output logic [1:0]         game_state,
  output logic [15:0]        frame_count,
  output logic               overrun,
  output logic               ack_timeout
);

  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int HW = $clog2(OVER_HOLD_FRAMES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OBJ - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
`ifdef GAME_FRAME_SEQ_AUTO_RESTART_EN
  localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_HOLD_FRAMES - 1);
`else
  localparam logic [HW-1:0] HOLD_DONE = HW'(OVER_HOLD_FRAMES);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  state_t          state;
  logic            v_sync_q;
  logic            start_q;
  logic            busy;       // sequence sub-FSM: 0 = WAIT, 1 = servicing idx
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   hold_cnt;
  logic            coll_pend;

  logic            vs_rise;
  logic            st_rise;
  logic            ack_hit;
  logic            tmo;
  logic [IW-1:0]   idx_nxt;

  assign vs_rise    = v_sync & ~v_sync_q;
  assign st_rise    = start_btn & ~start_q;
  // upd_req is one-hot on idx, so masking ignores acks from idle clients.
  assign ack_hit    = |(upd_ack & upd_req);
  assign tmo        = (tcnt == TMO_LAST);
  assign idx_nxt    = idx + 1'b1;
  assign game_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      v_sync_q    <= 1'b0;
      start_q     <= 1'b0;
      busy        <= 1'b0;
      idx         <= '0;
      tcnt        <= '0;
      hold_cnt    <= '0;
      coll_pend   <= 1'b0;
      upd_req     <= '0;
      obj_init    <= 1'b0;
      frame_count <= 16'd0;
      overrun     <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      v_sync_q <= v_sync;
      start_q  <= start_btn;
      obj_init <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (st_rise) begin
            state    <= ST_INIT;
            obj_init <= 1'b1;
          end
        end
        ST_INIT: begin
          state       <= ST_RUN;
          frame_count <= 16'd0;
          coll_pend   <= 1'b0;
          overrun     <= 1'b0;
          ack_timeout <= 1'b0;
          busy        <= 1'b0;
          idx         <= '0;
          tcnt        <= '0;
          upd_req     <= '0;
        end
        ST_RUN: begin
          if (!busy) begin
            // Collision beats a coincident v_sync edge: no new frame starts.
            if (collision || coll_pend) begin
              state     <= ST_OVER;
              hold_cnt  <= '0;
              coll_pend <= 1'b0;
            end else if (vs_rise) begin
              busy    <= 1'b1;
              idx     <= '0;
              tcnt    <= '0;
              upd_req <= NUM_OBJ'(1);
            end
          end else begin
            if (collision) coll_pend <= 1'b1;
            // Edge arriving mid-sequence is flagged and dropped.
            if (vs_rise) overrun <= 1'b1;
            if (ack_hit || tmo) begin
              if (!ack_hit) ack_timeout <= 1'b1;
              tcnt <= '0;
              if (idx == LAST_IDX) begin
                busy        <= 1'b0;
                upd_req     <= '0;
                frame_count <= frame_count + 16'd1;
                if (collision || coll_pend) begin
                  state     <= ST_OVER;
                  hold_cnt  <= '0;
                  coll_pend <= 1'b0;
                end
              end else begin
                idx     <= idx_nxt;
                upd_req <= NUM_OBJ'(1) << idx_nxt;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        ST_OVER: begin
          upd_req <= '0;
          busy    <= 1'b0;
`ifdef GAME_FRAME_SEQ_AUTO_RESTART_EN
          if (vs_rise) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_INIT;
              obj_init <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
`else
          if (hold_cnt == HOLD_DONE) begin
            if (st_rise) begin
              state    <= ST_INIT;
              obj_init <= 1'b1;
            end
          end else if (vs_rise) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_frame_sequencer.sv
// tb/tb_game_frame_sequencer.sv - directed self-checking bench for game_frame_sequencer
module tb_game_frame_sequencer;

  logic        clock;
  logic        reset;
  logic        v_sync;
  logic        start_btn;
  logic        collision;
  logic [3:0]  upd_req;
  logic [3:0]  upd_ack;
  logic        obj_init;
  logic [1:0]  game_state;
  logic [15:0] frame_count;
  logic        overrun;
  logic        ack_timeout;

  int          errors;
  int          checks;

  logic [15:0] seq_word;
  int          n_req;
  int          dur[8];
  bit          multi_hot;

  game_frame_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .v_sync      (v_sync),
    .start_btn   (start_btn),
    .collision   (collision),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .obj_init    (obj_init),
    .game_state  (game_state),
    .frame_count (frame_count),
    .overrun     (overrun),
    .ack_timeout (ack_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_vsync;
    v_sync = 1'b1;
    tick;
    v_sync = 1'b0;
    tick;
  endtask

  task automatic go_run;
    start_btn = 1'b1;
    tick;
    start_btn = 1'b0;
    tick;
  endtask

  // Triggers one frame and plays the client side until upd_req returns to 0.
  task automatic serve_frame(input int ack_delay, input logic [3:0] no_ack,
                             input bit noise, input int vs_at, input int col_at);
    logic [3:0] prev;
    bit done;
    seq_word  = 16'h0;
    n_req     = 0;
    multi_hot = 1'b0;
    done      = 1'b0;
    prev      = 4'h0;
    for (int k = 0; k < 8; k++) dur[k] = 0;
    v_sync = 1'b1;
    tick;
    v_sync = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      v_sync    = (c == vs_at);
      collision = (c == col_at);
      if ($countones(upd_req) > 1) multi_hot = 1'b1;
      if (upd_req == 4'h0) begin
        done = 1'b1;
      end else begin
        if (upd_req != prev) begin
          seq_word = {upd_req, seq_word[15:4]};
          if (n_req < 8) n_req++;
        end
        dur[n_req-1] = dur[n_req-1] + 1;
        if ((upd_req & no_ack) == 4'h0 && dur[n_req-1] == ack_delay)
          upd_ack = upd_req;
        else
          upd_ack = noise ? ~upd_req : 4'h0;
        prev = upd_req;
        tick;
      end
    end
    v_sync    = 1'b0;
    collision = 1'b0;
    upd_ack   = 4'h0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL seq_budget: upd_req=%b still active, required 0 within 600 cycles", upd_req);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick;
    tick;
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", game_state); end
    checks++; if (upd_req !== 4'h0) begin errors++; $display("FAIL rst_req: got %b want 0000", upd_req); end
    checks++; if (obj_init !== 1'b0) begin errors++; $display("FAIL rst_init: got %b want 0", obj_init); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_fc: got %0d want 0", frame_count); end
    checks++; if (overrun !== 1'b0 || ack_timeout !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b want 00", overrun, ack_timeout); end
    reset = 1'b1;
    tick;
    pulse_vsync;
    checks++; if (game_state !== 2'd0 || upd_req !== 4'h0) begin errors++; $display("FAIL idle_ignore: state=%0d req=%b want 0 0000", game_state, upd_req); end
  endtask

  task automatic test_start;
    start_btn = 1'b1;
    tick;
    checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL start_init: got %0d want 1", game_state); end
    checks++; if (obj_init !== 1'b1) begin errors++; $display("FAIL start_objinit: got %b want 1", obj_init); end
    start_btn = 1'b0;
    tick;
    checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL start_run: got %0d want 2", game_state); end
    checks++; if (obj_init !== 1'b0) begin errors++; $display("FAIL start_objinit_pulse: got %b want 0", obj_init); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL start_fc: got %0d want 0", frame_count); end
  endtask

  task automatic test_sequence;
    serve_frame(2, 4'h0, 1'b0, -1, -1);
    checks++; if (seq_word !== 16'h8421 || n_req != 4) begin errors++; $display("FAIL seq_order: got %h n=%0d want 8421 n=4", seq_word, n_req); end
    checks++; if (multi_hot) begin errors++; $display("FAIL seq_onehot: got multi-hot want one-hot"); end
    checks++; if (dur[0] != 2 || dur[3] != 2) begin errors++; $display("FAIL seq_dur: got %0d/%0d want 2/2", dur[0], dur[3]); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL seq_fc: got %0d want 1", frame_count); end
    checks++; if (ack_timeout !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL seq_flags: got %b%b want 00", overrun, ack_timeout); end
  endtask

  task automatic test_stray_ack;
    serve_frame(2, 4'h0, 1'b1, -1, -1);
    checks++; if (seq_word !== 16'h8421 || dur[1] != 2 || dur[2] != 2) begin errors++; $display("FAIL stray_ack: got %h d1=%0d d2=%0d want 8421 2 2", seq_word, dur[1], dur[2]); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL stray_fc: got %0d want 2", frame_count); end
  endtask

  task automatic test_timeout;
    serve_frame(2, 4'b0100, 1'b0, -1, -1);
    checks++; if (dur[2] != 255) begin errors++; $display("FAIL tmo_len: got %0d want 255", dur[2]); end
    checks++; if (seq_word !== 16'h8421) begin errors++; $display("FAIL tmo_order: got %h want 8421", seq_word); end
    checks++; if (ack_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1", ack_timeout); end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL tmo_fc: got %0d want 3", frame_count); end
  endtask

  task automatic test_overrun;
    serve_frame(2, 4'h0, 1'b0, 3, -1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    for (int k = 0; k < 5; k++) tick;
    checks++; if (upd_req !== 4'h0) begin errors++; $display("FAIL ovr_dropped: got %b want 0000", upd_req); end
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL ovr_fc: got %0d want 4", frame_count); end
  endtask

  task automatic test_collision;
    serve_frame(2, 4'h0, 1'b0, -1, 3);
    checks++; if (seq_word !== 16'h8421) begin errors++; $display("FAIL col_finish: got %h want 8421", seq_word); end
    checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL col_over: got %0d want 3", game_state); end
    checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL col_fc: got %0d want 5", frame_count); end
    for (int k = 0; k < 10; k++) pulse_vsync;
    go_run;
    checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL over_early_start: got %0d want 3", game_state); end
    checks++; if (frame_count !== 16'd5 || upd_req !== 4'h0) begin errors++; $display("FAIL over_frozen: fc=%0d req=%b want 5 0000", frame_count, upd_req); end
    for (int k = 0; k < 109; k++) pulse_vsync;
    v_sync = 1'b1;
    tick;
    v_sync = 1'b0;
`ifdef GAME_FRAME_SEQ_AUTO_RESTART_EN
    checks++; if (game_state !== 2'd1 || obj_init !== 1'b1) begin errors++; $display("FAIL auto_restart: state=%0d init=%b want 1 1", game_state, obj_init); end
    tick;
`else
    checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL hold_wait: got %0d want 3", game_state); end
    tick;
    start_btn = 1'b1;
    tick;
    start_btn = 1'b0;
    checks++; if (game_state !== 2'd1 || obj_init !== 1'b1) begin errors++; $display("FAIL restart_init: state=%0d init=%b want 1 1", game_state, obj_init); end
    tick;
`endif
    checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL restart_run: got %0d want 2", game_state); end
    checks++; if (overrun !== 1'b0 || ack_timeout !== 1'b0) begin errors++; $display("FAIL restart_flags: got %b%b want 00", overrun, ack_timeout); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL restart_fc: got %0d want 0", frame_count); end
  endtask

  task automatic test_reset_mid;
    v_sync = 1'b1;
    tick;
    v_sync = 1'b0;
    upd_ack = 4'b0001;
    tick;
    upd_ack = 4'h0;
    checks++; if (upd_req !== 4'b0010) begin errors++; $display("FAIL mid_pre: got %b want 0010", upd_req); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (upd_req !== 4'h0) begin errors++; $display("FAIL mid_async_req: got %b want 0000", upd_req); end
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL mid_async_state: got %0d want 0", game_state); end
    tick;
    reset = 1'b1;
    tick;
    checks++; if (game_state !== 2'd0 || frame_count !== 16'd0) begin errors++; $display("FAIL mid_release: state=%0d fc=%0d want 0 0", game_state, frame_count); end
  endtask

  task automatic test_simultaneous;
    go_run;
    collision = 1'b1;
    v_sync    = 1'b1;
    tick;
    collision = 1'b0;
    v_sync    = 1'b0;
    checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL simul_state: got %0d want 3", game_state); end
    tick;
    checks++; if (upd_req !== 4'h0 || frame_count !== 16'd0) begin errors++; $display("FAIL simul_noseq: req=%b fc=%0d want 0000 0", upd_req, frame_count); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    v_sync    = 1'b0;
    start_btn = 1'b0;
    collision = 1'b0;
    upd_ack   = 4'h0;
    test_reset;
    test_start;
    test_sequence;
    test_stray_ack;
    test_timeout;
    test_overrun;
    test_collision;
    test_reset_mid;
    test_simultaneous;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
